// File: rtl/spi_count_tx_if.sv
// spi_count_tx_if: request/handshake and SPI pins of the count transmitter.
// master = requester side, slave = transmitter side.
interface spi_count_tx_if;
  logic        start;
  logic [13:0] data;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        busy;
  logic        done;

  modport master (
    output start, data,
    input  sclk, mosi, cs_n, busy, done
  );

  modport slave (
    input  start, data,
    output sclk, mosi, cs_n, busy, done
  );
endinterface

// File: rtl/spi_count_tx.sv
// spi_count_tx: SPI mode-0 master sending the 14-bit count as one
// 16-bit MSB-first frame {2'b00, data}, with busy/done handshake.
module spi_count_tx #(
  parameter int CLK_DIV = 50
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_count_tx_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [7:0] HLAST = 8'(CLK_DIV - 1);

  logic [1:0]  state;
  logic [15:0] shreg;
  logic [3:0]  bcnt;
  logic [7:0]  hcnt;
  logic        sclk_q;
  logic        mosi_q;
  logic        cs_n_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] frame;
  logic        hwrap;

  assign frame = {2'b00, bus.data};
  assign hwrap = (hcnt == HLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bcnt   <= '0;
      hcnt   <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          sclk_q <= 1'b0;
          if (bus.start) begin
            shreg  <= frame;
            mosi_q <= frame[15];
            cs_n_q <= 1'b0;
            busy_q <= 1'b1;
            bcnt   <= '0;
            hcnt   <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (hwrap) begin
            hcnt   <= '0;
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              if (bcnt == 4'd15) begin
                cs_n_q <= 1'b1;
                mosi_q <= 1'b0;
                done_q <= 1'b1;
                state  <= GAP;
              end else begin
                // rotate keeps every bit live; only [14] is ever observed
                shreg  <= {shreg[14:0], shreg[15]};
                mosi_q <= shreg[14];
                bcnt   <= bcnt + 4'd1;
              end
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        GAP: begin
          sclk_q <= 1'b0;
          if (hwrap) begin
            hcnt   <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;
  assign bus.cs_n = cs_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
